// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin, lockable arbiter sharing the data memory
// between the core load/store path (m0) and a secondary master (m1).
`ifndef LOAD_SEL_B
`define LOAD_SEL_B  3'b000
`endif
`ifndef LOAD_SEL_H
`define LOAD_SEL_H  3'b001
`endif
`ifndef LOAD_SEL_W
`define LOAD_SEL_W  3'b010
`endif
`ifndef LOAD_SEL_BU
`define LOAD_SEL_BU 3'b100
`endif
`ifndef LOAD_SEL_HU
`define LOAD_SEL_HU 3'b101
`endif
`ifndef STORE_SEL_B
`define STORE_SEL_B 2'b00
`endif
`ifndef STORE_SEL_H
`define STORE_SEL_H 2'b01
`endif
`ifndef STORE_SEL_W
`define STORE_SEL_W 2'b10
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_load_sel,
  input  logic [1:0]  m0_store_sel,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_load_sel,
  input  logic [1:0]  m1_store_sel,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataW,
  output logic [2:0]  mem_load_sel,
  output logic [1:0]  mem_store_sel,
  output logic        mem_wr_en,
  input  logic [31:0] mem_dataR
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  state_e        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;

  logic [CW-1:0] base;
  logic [CW-1:0] n;
  logic          gnt_any;
  logic          gnt_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  // base is the burst count the granted requester continues from
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    base   = '0;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          m0_gnt = !rr_ptr_q;
          m1_gnt = rr_ptr_q;
        end else begin
          m0_gnt = m0_req;
          m1_gnt = m1_req;
        end
      end
      OWN0: begin
        if (m0_req) begin
          m0_gnt = 1'b1;
          base   = burst_cnt_q;
        end else begin
          m1_gnt = m1_req;
        end
      end
      OWN1: begin
        if (m1_req) begin
          m1_gnt = 1'b1;
          base   = burst_cnt_q;
        end else begin
          m0_gnt = m0_req;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end

    mem_addr      = '0;
    mem_dataW     = '0;
    mem_load_sel  = '0;
    mem_store_sel = '0;
    mem_wr_en     = ~`MEM_WRITE;
    unique case (1'b1)
      m0_gnt: begin
        mem_addr      = m0_addr;
        mem_dataW     = m0_wdata;
        mem_load_sel  = m0_load_sel;
        mem_store_sel = m0_store_sel;
        if (m0_we) mem_wr_en = `MEM_WRITE;
      end
      m1_gnt: begin
        mem_addr      = m1_addr;
        mem_dataW     = m1_wdata;
        mem_load_sel  = m1_load_sel;
        mem_store_sel = m1_store_sel;
        if (m1_we) mem_wr_en = `MEM_WRITE;
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt_any     = m0_gnt | m1_gnt;
    gnt_lock    = m1_gnt ? m1_lock : m0_lock;
    n           = base + CW'(1);
    state_d     = IDLE;
    burst_cnt_d = '0;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_any) begin
      if (gnt_lock && (n < CW'(MAX_BURST))) begin
        state_d     = m1_gnt ? OWN1 : OWN0;
        burst_cnt_d = n;
      end else begin
        rr_ptr_d = !m1_gnt;
      end
    end

    m0_rvalid_d = m0_gnt && !m0_we;
    m1_rvalid_d = m1_gnt && !m1_we;
    m0_rdata_d  = m0_rvalid_d ? mem_dataR : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? mem_dataR : m1_rdata_q;
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a
// byte-addressed memory model with hand-computed expectations.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_lock, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [2:0]  m0_load_sel;
  logic [1:0]  m0_store_sel;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_lock, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [2:0]  m1_load_sel;
  logic [1:0]  m1_store_sel;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic [31:0] mem_addr, mem_dataW, mem_dataR;
  logic [2:0]  mem_load_sel;
  logic [1:0]  mem_store_sel;
  logic        mem_wr_en;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_load_sel(m0_load_sel), .m0_store_sel(m0_store_sel),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_load_sel(m1_load_sel), .m1_store_sel(m1_store_sel),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_dataW(mem_dataW),
    .mem_load_sel(mem_load_sel), .mem_store_sel(mem_store_sel),
    .mem_wr_en(mem_wr_en), .mem_dataR(mem_dataR)
  );

  // memory model: little-endian bytes, 256-byte window
  logic [7:0] mem [256];
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    a0 = mem_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    case (mem_load_sel)
      3'b000:  mem_dataR = {{24{mem[a0][7]}}, mem[a0]};
      3'b001:  mem_dataR = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b010:  mem_dataR = {mem[a3], mem[a2], mem[a1], mem[a0]};
      3'b100:  mem_dataR = {24'd0, mem[a0]};
      3'b101:  mem_dataR = {16'd0, mem[a1], mem[a0]};
      default: mem_dataR = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[a0] <= mem_dataW[7:0];
      if (mem_store_sel != 2'b00) mem[a1] <= mem_dataW[15:8];
      if (mem_store_sel == 2'b10) begin
        mem[a2] <= mem_dataW[23:16];
        mem[a3] <= mem_dataW[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m0_load_sel = 0; m0_store_sel = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    m1_load_sel = 0; m1_store_sel = 0;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] exp0;
    clr();
    rst_n = 1'b0;
    m0_req = 1; m1_req = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt0", 32'(m0_gnt), 32'd0);
    check("rst_gnt1", 32'(m1_gnt), 32'd0);
    check("rst_rv0", 32'(m0_rvalid), 32'd0);
    check("rst_rd0", m0_rdata, 32'd0);
    check("rst_rd1", m1_rdata, 32'd0);
    clr();
    rst_n = 1'b1;

    // test 1: m0 store then load
    m0_req = 1; m0_we = 1; m0_addr = 32'h10;
    m0_wdata = 32'hDEADBEEF; m0_store_sel = 2'b10;
    #1;
    check("t1_st_gnt0", 32'(m0_gnt), 32'd1);
    check("t1_st_gnt1", 32'(m1_gnt), 32'd0);
    check("t1_st_wen", 32'(mem_wr_en), 32'd1);
    check("t1_st_addr", mem_addr, 32'h10);
    check("t1_st_data", mem_dataW, 32'hDEADBEEF);
    @(negedge clk);
    m0_we = 0; m0_load_sel = 3'b010;
    #1;
    check("t1_ld_gnt0", 32'(m0_gnt), 32'd1);
    check("t1_ld_wen", 32'(mem_wr_en), 32'd0);
    check("t1_st_norv", 32'(m0_rvalid), 32'd0);
    @(negedge clk);
    check("t1_rv", 32'(m0_rvalid), 32'd1);
    check("t1_rd", m0_rdata, 32'hDEADBEEF);
    check("t1_rv1", 32'(m1_rvalid), 32'd0);
    clr();
    #1;
    check("t1_idle_gnt", 32'(m0_gnt), 32'd0);
    @(negedge clk);
    check("t1_rv_pulse", 32'(m0_rvalid), 32'd0);
    check("t1_rd_hold", m0_rdata, 32'hDEADBEEF);

    // test 2: round robin without lock
    do_reset();
    m0_req = 1; m0_addr = 32'h100; m0_load_sel = 3'b010;
    m1_req = 1; m1_addr = 32'h200; m1_load_sel = 3'b010;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t2_gnt0_%0d", i), 32'(m0_gnt), 32'((i % 2) == 0));
      check($sformatf("t2_gnt1_%0d", i), 32'(m1_gnt), 32'((i % 2) == 1));
      check($sformatf("t2_addr_%0d", i), mem_addr,
            (i % 2 == 0) ? 32'h100 : 32'h200);
      @(negedge clk);
    end
    clr();

    // test 3: locked burst capped at MAX_BURST
    do_reset();
    exp0 = 6'b101111;
    m0_req = 1; m0_lock = 1; m0_addr = 32'h40; m0_load_sel = 3'b010;
    m1_req = 1; m1_addr = 32'h80; m1_load_sel = 3'b010;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t3_gnt0_%0d", i), 32'(m0_gnt), 32'(exp0[i]));
      check($sformatf("t3_gnt1_%0d", i), 32'(m1_gnt), 32'(!exp0[i]));
      @(negedge clk);
    end
    clr();

    // test 4: owner drops request, hand-over in same cycle
    do_reset();
    m0_req = 1; m0_lock = 1; m0_load_sel = 3'b010;
    m1_req = 1; m1_load_sel = 3'b010;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("t4_own_%0d", i), 32'(m0_gnt), 32'd1);
      @(negedge clk);
    end
    m0_req = 0;
    #1;
    check("t4_hand_gnt1", 32'(m1_gnt), 32'd1);
    check("t4_hand_gnt0", 32'(m0_gnt), 32'd0);
    @(negedge clk);
    clr();

    // test 5: store byte then cross-requester signed/unsigned loads
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h21;
    m0_wdata = 32'h00000080; m0_store_sel = 2'b00;
    #1;
    check("t5_st_gnt", 32'(m0_gnt), 32'd1);
    @(negedge clk);
    m0_req = 0; m0_we = 0;
    m1_req = 1; m1_addr = 32'h21; m1_load_sel = 3'b000;
    #1;
    check("t5_lb_gnt", 32'(m1_gnt), 32'd1);
    @(negedge clk);
    check("t5_lb_rv", 32'(m1_rvalid), 32'd1);
    check("t5_lb", m1_rdata, 32'hFFFFFF80);
    m1_load_sel = 3'b100;
    #1;
    check("t5_lbu_gnt", 32'(m1_gnt), 32'd1);
    @(negedge clk);
    check("t5_lbu", m1_rdata, 32'h00000080);
    clr();

    // test 6: reset during a locked burst with a pending rvalid
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h10; m0_load_sel = 3'b010;
    m1_req = 1; m1_load_sel = 3'b010;
    #1;
    check("t6_ld_gnt", 32'(m0_gnt), 32'd1);
    @(negedge clk);
    check("t6_rv_pre", 32'(m0_rvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rv_rst", 32'(m0_rvalid), 32'd0);
    check("t6_gnt0_rst", 32'(m0_gnt), 32'd0);
    check("t6_gnt1_rst", 32'(m1_gnt), 32'd0);
    @(negedge clk);
    check("t6_rv_rst2", 32'(m0_rvalid), 32'd0);
    check("t6_rd_rst", m0_rdata, 32'd0);
    m0_lock = 0;
    rst_n = 1'b1;
    #1;
    check("t6_post_gnt0", 32'(m0_gnt), 32'd1);
    check("t6_post_gnt1", 32'(m1_gnt), 32'd0);
    @(negedge clk);
    #1;
    check("t6_post_rr", 32'(m1_gnt), 32'd1);
    clr();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port byte-addressed data memory between the core load/store path (requester 0) and a secondary master such as debug or DMA (requester 1). It grants one access per cycle using round-robin priority, with optional bounded locking for bursts. It drives the memory's address, data, load/store select and write-enable lines, and returns registered read data to the granted requester one cycle after the grant. It sits between the requesters and the data memory. Select encodings are the shared LOAD_SEL_* / STORE_SEL_* macros, and write enable uses MEM_WRITE.

Parameters:
MAX_BURST, 4, maximum consecutive grants one requester may hold under lock before forced release; legal range >=1, and 1 disables locking.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
m0_req  input  1  requester 0 access request, held until granted
m0_lock  input  1  requester 0 asks to keep ownership after this grant
m0_we  input  1  1 = store, 0 = load
m0_addr  input  32  byte address
m0_wdata  input  32  store data
m0_load_sel  input  3  load type
m0_store_sel  input  2  store type
m0_gnt  output  1  access issued to memory this cycle (combinational)
m0_rvalid  output  1  read data valid (registered)
m0_rdata  output  32  read data (registered)
m1_*  same set as m0_*  requester 1
mem_addr  output  32  to memory addr
mem_dataW  output  32  to memory write data
mem_load_sel  output  3  to memory load select
mem_store_sel  output  2  to memory store select
mem_wr_en  output  1  to memory write enable
mem_dataR  input  32  combinational read data from memory

Behaviour:
- State registers:
  - owner FSM with states IDLE, OWN0, OWN1.
  - rr_ptr (1 bit): the requester that wins a tie.
  - burst_cnt: width clog2(MAX_BURST+1).
- Reset (asynchronous): state=IDLE, rr_ptr=0, burst_cnt=0, m0/m1_rvalid=0, m0/m1_rdata=0. The gnt outputs are 0 while rst_n is low.
- Grant decision is combinational in the current cycle:
  - IDLE, only one req high: grant that requester.
  - IDLE, both req high: grant rr_ptr.
  - OWNx with mx_req=1: grant x only; the other requester waits.
  - OWNx with mx_req=0: ownership ends. Arbitrate as in IDLE with priority to the other requester, and grant it in the same cycle if it is requesting.
- Memory mux:
  - Granted requester's addr, wdata, load_sel and store_sel drive the mem_* lines.
  - mem_wr_en = MEM_WRITE when gnt and we=1; otherwise deasserted.
  - No grant: all mem_* outputs 0 and mem_wr_en deasserted.
  - Stores commit at the rising edge ending the grant cycle.
- State update on each grant to requester x:
  - Compute n = burst_cnt+1, where burst_cnt is 0 when arriving from IDLE or from a hand-over.
  - If mx_lock=1 and n<MAX_BURST: next state OWNx, burst_cnt=n.
  - Otherwise: next state IDLE, burst_cnt=0, rr_ptr = other(x). This is the forced release when n reaches MAX_BURST, even with lock high.
- No grant in a cycle: state=IDLE, burst_cnt=0, rr_ptr unchanged.
- Read response:
  - A granted load (we=0) sets mx_rvalid=1 and mx_rdata=mem_dataR at the next edge, giving exactly 1-cycle latency.
  - rvalid is a single-cycle pulse per load. Back-to-back loads give rvalid on consecutive cycles.
  - Stores never assert rvalid.
  - rdata holds its last value when rvalid=0.
- Ordering: a store granted in cycle t is visible to a load from either requester granted in cycle t+1.
- Requesters must hold req and all request fields stable until gnt. Dropping req before gnt is legal; no access occurs.
- Illegal load_sel or store_sel values pass through unchanged. The memory returns 0 or does nothing, and rvalid still pulses for a load.
- Reset mid-operation: ownership and the burst count are discarded, any pending rvalid is cleared, and there is no grant during reset.

Test Plan:
1. m0 alone issues a W store of 0xDEADBEEF to 0x10, then a W load from 0x10 -> m0_gnt in both cycles; m0_rvalid=1 with rdata=0xDEADBEEF in the cycle after the load grant; m1 sees no activity.
2. Both requesters hold req with lock=0 for 6 cycles from reset -> grant order 0,1,0,1,0,1; exactly one gnt per cycle; mem_addr follows the winner each cycle.
3. m0 holds req and lock=1, m1 requests continuously, MAX_BURST=4 -> m0 granted 4 consecutive cycles, m1 granted in cycle 5, then m0 again.
4. m0 locks and is granted 2 cycles, then drops req while m1 requests -> m1 granted in that same cycle; no idle bubble.
5. m0 stores byte 0x80 at 0x21 in cycle t, m1 issues a B load from 0x21 in cycle t+1 -> m1_rdata=0xFFFFFF80; BU load gives 0x00000080.
6. rst_n asserted low mid-burst, one cycle after a load grant -> rvalid stays 0, gnt=0 during reset; after release, state is IDLE and both requesting gives m0 first.
